// File: rtl/pipelined_inst_decoder_pkg.sv
// Shared widths, control-word layout and helpers for the registered instruction decode stage.
// Control word layout, MSB to LSB: {DA, AA, BA, FS[3:0], MB, MD, RW, MW, PL, JB, BC}.
package pipelined_inst_decoder_pkg;

  localparam int FS_W   = 4;
  localparam int CTRL_W = 7;

  // Bit positions of the single-bit controls inside the low CTRL_W bits of the control word
  localparam int CB_BC = 0;
  localparam int CB_JB = 1;
  localparam int CB_PL = 2;
  localparam int CB_MW = 3;
  localparam int CB_RW = 4;
  localparam int CB_MD = 5;
  localparam int CB_MB = 6;

  localparam int FS_LSB = CTRL_W;
  localparam int BA_LSB = CTRL_W + FS_W;

  typedef struct packed {
    logic mb;
    logic md;
    logic rw;
    logic mw;
    logic pl;
    logic jb;
    logic bc;
  } ctrl_t;

  function automatic int inst_width(input int aw);
    return 3 * aw + 7;
  endfunction

  function automatic int cw_width(input int aw);
    return 3 * aw + FS_W + CTRL_W;
  endfunction

  function automatic int aa_lsb(input int aw);
    return BA_LSB + aw;
  endfunction

  function automatic int da_lsb(input int aw);
    return BA_LSB + 2 * aw;
  endfunction

endpackage

// File: rtl/pipelined_inst_decoder_field_decode.sv
// Purely combinational instruction-word to control-word decode.
module pipelined_inst_decoder_field_decode
  import pipelined_inst_decoder_pkg::*;
#(
  parameter  int AW     = 3,
  localparam int INST_W = inst_width(AW),
  localparam int CW_W   = cw_width(AW)
) (
  input  logic [INST_W-1:0] i_inst,
  output logic [CW_W-1:0]   o_cw
);

  localparam int T = INST_W - 1;

  ctrl_t           w_ctrl;
  logic [FS_W-1:0] w_fs;

  always_comb begin
    w_ctrl    = '0;
    w_ctrl.mb = i_inst[T];
    w_ctrl.md = i_inst[T-2];
    w_ctrl.jb = i_inst[T-2];
    w_ctrl.rw = ~i_inst[T-1];
    w_ctrl.mw = i_inst[T-1] & ~i_inst[T];
    w_ctrl.pl = i_inst[T-1] & i_inst[T];
    w_ctrl.bc = i_inst[3*AW];
    // The branch-condition bit doubles as FS[0] except on PL-type words
    w_fs      = {i_inst[T-3:T-5], i_inst[3*AW] & ~w_ctrl.pl};
  end

  // DA, AA, BA sit contiguously at the bottom of the instruction in the same order as the control word
  assign o_cw = {i_inst[3*AW-1:0], w_fs, w_ctrl};

endmodule

// File: rtl/pipelined_inst_decoder.sv
// Registered decode stage: valid/ready input, output register backed by a one-entry skid buffer,
// flush and load-use bubble insertion.
module pipelined_inst_decoder
  import pipelined_inst_decoder_pkg::*;
#(
  parameter  int AW           = 3,
  parameter  int LOAD_USE_BUB = 1,
  localparam int INST_W       = inst_width(AW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_da,
  output logic [AW-1:0]     out_aa,
  output logic [AW-1:0]     out_ba,
  output logic [FS_W-1:0]   out_fs,
  output logic              out_mb,
  output logic              out_md,
  output logic              out_rw,
  output logic              out_mw,
  output logic              out_pl,
  output logic              out_jb,
  output logic              out_bc,
  output logic              hazard
);

  localparam int         CW_W     = cw_width(AW);
  localparam int         AA_LSB   = aa_lsb(AW);
  localparam int         DA_LSB   = da_lsb(AW);
  localparam bit         BUB_EN   = (LOAD_USE_BUB != 0);
  localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUB);

  logic              r_out_valid;
  logic [CW_W-1:0]   r_out_cw;
  logic              r_skd_valid;
  logic [INST_W-1:0] r_skd_inst;
  logic [AW-1:0]     r_ld_da;
  logic [1:0]        r_cnt;

  logic [INST_W-1:0] w_cand_inst;
  logic              w_cand_valid;
  logic [CW_W-1:0]   w_cand_cw;
  logic [AW-1:0]     w_cand_aa;
  logic [AW-1:0]     w_cand_ba;
  logic              w_cand_mb;
  ctrl_t             w_out_ctrl;
  logic [AW-1:0]     w_out_da;
  logic              w_out_xfer;
  logic              w_out_free;
  logic              w_out_is_load;
  logic              w_haz_inflight;
  logic              w_haz_pending;
  logic              w_hazard;
  logic              w_load_out;
  logic              w_in_xfer;

  function automatic logic f_reads(input logic [AW-1:0] addr, input logic [AW-1:0] aa,
                                   input logic [AW-1:0] ba, input logic mb);
    return (aa == addr) | (~mb & (ba == addr));
  endfunction

  // A parked word always has priority over the input port so ordering is kept
  assign w_cand_inst  = r_skd_valid ? r_skd_inst : in_inst;
  assign w_cand_valid = r_skd_valid | in_valid;

  pipelined_inst_decoder_field_decode #(
    .AW (AW)
  ) u_field_decode (
    .i_inst (w_cand_inst),
    .o_cw   (w_cand_cw)
  );

  assign w_cand_aa = w_cand_cw[AA_LSB +: AW];
  assign w_cand_ba = w_cand_cw[BA_LSB +: AW];
  assign w_cand_mb = w_cand_cw[CB_MB];

  assign w_out_ctrl    = ctrl_t'(r_out_cw[CTRL_W-1:0]);
  assign w_out_da      = r_out_cw[DA_LSB +: AW];
  assign w_out_xfer    = r_out_valid & out_ready;
  assign w_out_free    = ~r_out_valid | w_out_xfer;
  assign w_out_is_load = w_out_ctrl.md & w_out_ctrl.rw;

  // The cycle a load leaves OUT is itself the first bubble slot; the counter then covers the rest
  assign w_haz_inflight = w_out_xfer & w_out_is_load & f_reads(w_out_da, w_cand_aa, w_cand_ba, w_cand_mb);
  assign w_haz_pending  = (r_cnt > 2'd1) & f_reads(r_ld_da, w_cand_aa, w_cand_ba, w_cand_mb);
  assign w_hazard       = BUB_EN & w_cand_valid & (w_haz_inflight | w_haz_pending);

  assign w_load_out = w_cand_valid & w_out_free & ~w_hazard;
  assign w_in_xfer  = in_valid & ~r_skd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_cw    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_cw    <= w_cand_cw;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skd_valid <= 1'b0;
      r_skd_inst  <= '0;
    end else if (flush) begin
      r_skd_valid <= 1'b0;
    end else if (r_skd_valid) begin
      if (w_load_out) begin
        r_skd_valid <= 1'b0;
      end
    end else if (w_in_xfer && !w_load_out) begin
      r_skd_valid <= 1'b1;
      r_skd_inst  <= in_inst;
    end
  end

  // A newer load leaving OUT simply overwrites the tracked destination and restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_da <= '0;
      r_cnt   <= 2'd0;
    end else if (flush) begin
      r_cnt <= 2'd0;
    end else if (BUB_EN && w_out_xfer && w_out_is_load) begin
      r_ld_da <= w_out_da;
      r_cnt   <= BUB_INIT;
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign in_ready  = ~r_skd_valid;
  assign out_valid = r_out_valid;
  assign hazard    = w_hazard;

  assign out_da = w_out_da;
  assign out_aa = r_out_cw[AA_LSB +: AW];
  assign out_ba = r_out_cw[BA_LSB +: AW];
  assign out_fs = r_out_cw[FS_LSB +: FS_W];
  assign out_mb = w_out_ctrl.mb;
  assign out_md = w_out_ctrl.md;
  assign out_rw = w_out_ctrl.rw;
  assign out_mw = w_out_ctrl.mw;
  assign out_pl = w_out_ctrl.pl;
  assign out_jb = w_out_ctrl.jb;
  assign out_bc = w_out_ctrl.bc;

endmodule

// File: tb/tb_pipelined_inst_decoder.sv
// Self-checking bench for pipelined_inst_decoder: decode table, load-use bubbles, backpressure,
// flush, async reset and a random stream, all backed by an in-order scoreboard.
module tb_pipelined_inst_decoder;

  localparam int AW     = 3;
  localparam int INST_W = 3 * AW + 7;
  localparam int CW_W   = 3 * AW + 11;
  localparam int T      = INST_W - 1;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              flush     = 1'b0;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] in_inst   = '0;

  logic          in_ready, out_valid, hazard;
  logic [AW-1:0] out_da, out_aa, out_ba;
  logic [3:0]    out_fs;
  logic          out_mb, out_md, out_rw, out_mw, out_pl, out_jb, out_bc;

  logic          nb_in_ready, nb_out_valid, nb_hazard;
  logic [AW-1:0] nb_da, nb_aa, nb_ba;
  logic [3:0]    nb_fs;
  logic          nb_mb, nb_md, nb_rw, nb_mw, nb_pl, nb_jb, nb_bc;

  logic [CW_W-1:0] act_cw, nb_cw;
  assign act_cw = {out_da, out_aa, out_ba, out_fs, out_mb, out_md, out_rw, out_mw, out_pl, out_jb, out_bc};
  assign nb_cw  = {nb_da, nb_aa, nb_ba, nb_fs, nb_mb, nb_md, nb_rw, nb_mw, nb_pl, nb_jb, nb_bc};

  always #5 clk = ~clk;

  pipelined_inst_decoder #(.AW(AW), .LOAD_USE_BUB(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_da(out_da), .out_aa(out_aa), .out_ba(out_ba), .out_fs(out_fs),
    .out_mb(out_mb), .out_md(out_md), .out_rw(out_rw), .out_mw(out_mw),
    .out_pl(out_pl), .out_jb(out_jb), .out_bc(out_bc), .hazard(hazard)
  );

  // Second build with bubbling disabled, fed the same stimulus
  pipelined_inst_decoder #(.AW(AW), .LOAD_USE_BUB(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready), .in_inst(in_inst),
    .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready),
    .out_da(nb_da), .out_aa(nb_aa), .out_ba(nb_ba), .out_fs(nb_fs),
    .out_mb(nb_mb), .out_md(nb_md), .out_rw(nb_rw), .out_mw(nb_mw),
    .out_pl(nb_pl), .out_jb(nb_jb), .out_bc(nb_bc), .hazard(nb_hazard)
  );

  typedef struct {
    logic [15:0] inst;
    logic [2:0]  da, aa, ba;
    logic [3:0]  fs;
    logic        mb, md, rw, mw, pl, jb, bc;
  } vec_t;

  vec_t            vecs[8];
  logic [CW_W-1:0] sb_q[$];
  int              errors = 0;
  int              checks = 0;
  int              txn_n  = 0;

  function automatic logic [CW_W-1:0] vexp(input vec_t v);
    return {v.da, v.aa, v.ba, v.fs, v.mb, v.md, v.rw, v.mw, v.pl, v.jb, v.bc};
  endfunction

  function automatic logic [CW_W-1:0] model(input logic [INST_W-1:0] i);
    logic mb, md, rw, mw, pl, jb, bc;
    logic [3:0] fs;
    mb = i[T];
    md = i[T-2];
    jb = i[T-2];
    rw = ~i[T-1];
    mw = i[T-1] & ~i[T];
    pl = i[T-1] & i[T];
    bc = i[3*AW];
    fs = {i[T-3:T-5], bc & ~pl};
    return {i[3*AW-1:2*AW], i[2*AW-1:AW], i[AW-1:0], fs, mb, md, rw, mw, pl, jb, bc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Observes the transfers that the coming rising edge will perform
  task automatic sb_sample();
    logic [CW_W-1:0] e;
    if (!rst_n) return;
    if (out_valid && out_ready) begin
      chk("sb_expected_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_out_cw", 32'(act_cw), 32'(e));
        txn_n++;
        $display("txn %0d: out cw=0x%0h expected 0x%0h", txn_n, act_cw, e);
      end
    end
    if (flush) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back(model(in_inst));
  endtask

  task automatic tick();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_seen;
    logic accepted;

    vecs[0] = '{16'h0453, 3'd1, 3'd2, 3'd3, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h401C, 3'd0, 3'd3, 3'd4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'hC000, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h2110, 3'd4, 3'd2, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0561, 3'd5, 3'd4, 3'd1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h8200, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'hE3FF, 3'd7, 3'd7, 3'd7, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h1C00, 3'd0, 3'd0, 3'd0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_fields", 32'(act_cw), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode table, one instruction at a time with 1-cycle latency
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      in_inst  = vecs[v].inst;
      tick();
      in_valid = 1'b0;
      chk("dec_latency_valid", 32'(out_valid), 32'd1);
      chk("dec_fields", 32'(act_cw), 32'(vexp(vecs[v])));
      tick();
    end
    tick();
    tick();

    // Load-use: LD R4 then a reader of R4 -> exactly one bubble; no bubble without bubbling
    in_valid = 1'b1;
    in_inst  = vecs[3].inst;
    tick();
    in_inst = vecs[4].inst;
    #1;
    chk("lu_hazard_asserted", 32'(hazard), 32'd1);
    chk("lu_nb_hazard", 32'(nb_hazard), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("lu_bubble_valid", 32'(out_valid), 32'd0);
    chk("lu_bubble_hazard", 32'(hazard), 32'd0);
    chk("lu_nb_no_bubble", 32'(nb_out_valid), 32'd1);
    chk("lu_nb_fields", 32'(nb_cw), 32'(vexp(vecs[4])));
    chk("lu_nb_ready", 32'(nb_in_ready), 32'd1);
    tick();
    chk("lu_dep_valid", 32'(out_valid), 32'd1);
    chk("lu_dep_fields", 32'(act_cw), 32'(vexp(vecs[4])));
    tick();
    chk("lu_no_dup", 32'(out_valid), 32'd0);
    tick();
    tick();

    // Independent instruction after a load issues without a bubble
    in_valid = 1'b1;
    in_inst  = vecs[3].inst;
    tick();
    in_inst = vecs[0].inst;
    #1;
    chk("lu_indep_hazard", 32'(hazard), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("lu_indep_valid", 32'(out_valid), 32'd1);
    chk("lu_indep_fields", 32'(act_cw), 32'(vexp(vecs[0])));
    tick();
    tick();
    tick();

    // Backpressure: OUT and SKD fill, third word stalls, order kept on release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = vecs[7].inst;
    tick();
    in_inst = vecs[0].inst;
    chk("bp_ready_second", 32'(in_ready), 32'd1);
    tick();
    in_inst = vecs[1].inst;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_head", 32'(act_cw), 32'(vexp(vecs[7])));
    tick();
    tick();
    chk("bp_still_stalled", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      if (in_ready) accepted = 1'b1;
      tick();
    end
    chk("bp_third_accepted", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("bp_drained", 32'(sb_q.size()), 32'd0);

    // Flush with OUT and SKD full and a word on the input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = vecs[0].inst;
    tick();
    in_inst = vecs[3].inst;
    tick();
    chk("fl_full_before", 32'(in_ready), 32'd0);
    in_inst = vecs[5].inst;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    n_seen    = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) n_seen++;
      tick();
    end
    chk("fl_no_ghost", 32'(n_seen), 32'd0);

    // Random stream with random backpressure and occasional flush
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_inst   = INST_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (sb_q.size() != 0 || out_valid); k++) tick();
    chk("rand_drained", 32'(sb_q.size()), 32'd0);
    chk("rand_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream, off the clock edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = vecs[3].inst;
    tick();
    in_inst = vecs[6].inst;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_fields", 32'(act_cw), 32'd0);
    chk("arst_hazard", 32'(hazard), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_no_partial", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = vecs[0].inst;
    tick();
    in_valid = 1'b0;
    chk("arst_resume_valid", 32'(out_valid), 32'd1);
    chk("arst_resume_fields", 32'(act_cw), 32'(vexp(vecs[0])));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
